// File: rtl/hazard_stall_ctrl_if.sv
// ID-stage hazard bus: register indices and control flags in, stall controls out.
// stall_count is present only when HAZARD_STATS_EN is defined.
interface hazard_stall_ctrl_if #(
  parameter int unsigned REG_W = 5
);
  logic [REG_W-1:0] rs_id;
  logic [REG_W-1:0] rt_id;
  logic             uses_rt_id;
  logic             branch_id;
  logic [REG_W-1:0] rd_ex;
  logic             reg_write_ex;
  logic             mem_read_ex;
  logic [REG_W-1:0] rd_ex_m;
  logic             mem_read_m;
  logic             freeze;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_flush;
  logic             stall_active;
`ifdef HAZARD_STATS_EN
  logic [15:0]      stall_count;
`endif

  modport master (
    output rs_id, rt_id, uses_rt_id, branch_id, rd_ex, reg_write_ex, mem_read_ex,
    output rd_ex_m, mem_read_m, freeze,
    input  pc_write, if_id_write, id_ex_flush, stall_active
`ifdef HAZARD_STATS_EN
    , input stall_count
`endif
  );

  modport slave (
    input  rs_id, rt_id, uses_rt_id, branch_id, rd_ex, reg_write_ex, mem_read_ex,
    input  rd_ex_m, mem_read_m, freeze,
    output pc_write, if_id_write, id_ex_flush, stall_active
`ifdef HAZARD_STATS_EN
    , output stall_count
`endif
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-operand stall controller with a 2-state IDLE/HOLD FSM.
// Optional saturating stall-cycle counter enabled by defining HAZARD_STATS_EN.
module hazard_stall_ctrl #(
  parameter int unsigned REG_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_stall_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e           r_state, w_state_d;
  logic [1:0]       r_rem_cnt, w_rem_cnt_d;
  logic [REG_W-1:0] w_rs, w_rt, w_rd_ex, w_rd_m;
  logic             w_match_ex, w_match_m;
  logic [1:0]       w_need;
  logic             w_stall;
  logic             w_flush;

  assign w_rs    = bus.rs_id;
  assign w_rt    = bus.rt_id;
  assign w_rd_ex = bus.rd_ex;
  assign w_rd_m  = bus.rd_ex_m;

  // Register 0 is hardwired, so it never creates a dependency.
  assign w_match_ex = (w_rd_ex != '0) &&
                      ((w_rd_ex == w_rs) || (bus.uses_rt_id && (w_rd_ex == w_rt)));
  assign w_match_m  = (w_rd_m != '0) &&
                      ((w_rd_m == w_rs) || (bus.uses_rt_id && (w_rd_m == w_rt)));

  always_comb begin
    w_need = 2'd0;
    if (bus.branch_id) begin
      if (w_match_ex && bus.mem_read_ex)       w_need = 2'd2;
      else if (w_match_ex && bus.reg_write_ex) w_need = 2'd1;
      else if (w_match_m && bus.mem_read_m)    w_need = 2'd1;
    end else if (w_match_ex && bus.mem_read_ex) begin
      w_need = 2'd1;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_rem_cnt_d = r_rem_cnt;
    w_stall     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_stall = (w_need != 2'd0);
        if (w_need == 2'd2) begin
          w_state_d   = StHold;
          w_rem_cnt_d = 2'd1;
        end
      end
      StHold: begin
        w_stall = 1'b1;
        if (r_rem_cnt <= 2'd1) begin
          w_state_d   = StIdle;
          w_rem_cnt_d = 2'd0;
        end else begin
          w_rem_cnt_d = r_rem_cnt - 2'd1;
        end
      end
      default: begin
        w_state_d   = StIdle;
        w_rem_cnt_d = 2'd0;
      end
    endcase
    if (bus.freeze) begin
      w_state_d   = r_state;
      w_rem_cnt_d = r_rem_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_rem_cnt <= 2'd0;
    end else begin
      r_state   <= w_state_d;
      r_rem_cnt <= w_rem_cnt_d;
    end
  end

  // Reset forces pass-through even if the live inputs describe a hazard.
  assign w_flush          = rst_n && !bus.freeze && w_stall;
  assign bus.id_ex_flush  = w_flush;
  assign bus.pc_write     = !rst_n || (!bus.freeze && !w_stall);
  assign bus.if_id_write  = !rst_n || (!bus.freeze && !w_stall);
  assign bus.stall_active = (r_state == StHold);

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= 16'd0;
    end else if (w_flush && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign bus.stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: directed vector table, hand-written multi-cycle sequences and
// random stimulus against a rule-level reference model.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_W(5)) bus ();

  hazard_stall_ctrl #(.REG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses, br;
    logic [4:0] rd_ex;
    logic       rw_ex, mr_ex;
    logic [4:0] rd_m;
    logic       mr_m, frz;
  } stim_t;

  typedef struct {
    stim_t s;
    logic  pc;
    logic  flush;
  } vec_t;

  int         n_chk = 0;
  int         n_fail = 0;
  int         m_hold = 0;   // remaining HOLD cycles the model expects
  int         m_cnt = 0;    // expected stall_count
  logic [3:0] last;         // {pc_write, if_id_write, id_ex_flush, stall_active}
  vec_t       tbl[12];
  stim_t      clean;

  function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                               input logic br, input logic [4:0] rd_ex, input logic rw_ex,
                               input logic mr_ex, input logic [4:0] rd_m, input logic mr_m,
                               input logic frz);
    stim_t s;
    s.rs = rs; s.rt = rt; s.uses = uses; s.br = br; s.rd_ex = rd_ex; s.rw_ex = rw_ex;
    s.mr_ex = mr_ex; s.rd_m = rd_m; s.mr_m = mr_m; s.frz = frz;
    return s;
  endfunction

  function automatic bit hit(input logic [4:0] d, input stim_t s);
    return (d != 0) && ((d == s.rs) || (s.uses && (d == s.rt)));
  endfunction

  // Stall cycles demanded by the ID instruction against current EX/MEM contents.
  function automatic int need(input stim_t s);
    bit hx = hit(s.rd_ex, s);
    bit hm = hit(s.rd_m, s);
    if (s.br) begin
      if (hx && s.mr_ex) return 2;
      if (hx && s.rw_ex) return 1;
      if (hm && s.mr_m)  return 1;
      return 0;
    end
    return (hx && s.mr_ex) ? 1 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    bus.rs_id = s.rs;  bus.rt_id = s.rt;  bus.uses_rt_id = s.uses;  bus.branch_id = s.br;
    bus.rd_ex = s.rd_ex;  bus.reg_write_ex = s.rw_ex;  bus.mem_read_ex = s.mr_ex;
    bus.rd_ex_m = s.rd_m;  bus.mem_read_m = s.mr_m;  bus.freeze = s.frz;
  endtask

  // One clock cycle: drive after negedge, compare mid-cycle, advance model at posedge.
  task automatic step(input stim_t s, input string tag);
    logic       st, ha;
    logic [3:0] exp;
    drive(s);
    #1;
    ha  = (m_hold > 0);
    st  = ha || (need(s) > 0);
    exp = s.frz ? {3'b000, ha} : {!st, !st, st, ha};
    last = {bus.pc_write, bus.if_id_write, bus.id_ex_flush, bus.stall_active};
    check(tag, 32'(last), 32'(exp));
`ifdef HAZARD_STATS_EN
    check({tag, "/count"}, 32'(bus.stall_count), 32'(m_cnt));
`endif
    @(posedge clk);
    if (!s.frz) begin
      if (st && m_cnt < 65535) m_cnt++;
      if (m_hold > 0) m_hold--;
      else if (need(s) == 2) m_hold = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    stim_t lu, bl, ba, r;
    int    c0;
    clean = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(lu_hazard());
    #3;
    last = {bus.pc_write, bus.if_id_write, bus.id_ex_flush, bus.stall_active};
    check("reset_outputs", 32'(last), 32'(4'b1100));
`ifdef HAZARD_STATS_EN
    check("reset_count", 32'(bus.stall_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // rs, rt, uses, br, rd_ex, rw_ex, mr_ex, rd_m, mr_m, frz -> pc, flush
    tbl[0]  = '{s: mk(5, 0, 0, 0, 5, 1, 1, 0, 0, 0), pc: 1'b0, flush: 1'b1};
    tbl[1]  = '{s: mk(0, 7, 1, 1, 7, 1, 1, 0, 0, 0), pc: 1'b0, flush: 1'b1};
    tbl[2]  = '{s: mk(3, 0, 0, 1, 3, 1, 0, 0, 0, 0), pc: 1'b0, flush: 1'b1};
    tbl[3]  = '{s: mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0), pc: 1'b1, flush: 1'b0};
    tbl[4]  = '{s: mk(1, 9, 0, 0, 9, 1, 1, 0, 0, 0), pc: 1'b1, flush: 1'b0};
    tbl[5]  = '{s: mk(4, 0, 0, 1, 0, 0, 0, 4, 1, 0), pc: 1'b0, flush: 1'b1};
    tbl[6]  = '{s: mk(4, 0, 0, 0, 0, 0, 0, 4, 1, 0), pc: 1'b1, flush: 1'b0};
    tbl[7]  = '{s: mk(6, 0, 0, 0, 6, 1, 0, 0, 0, 0), pc: 1'b1, flush: 1'b0};
    tbl[8]  = '{s: mk(4, 0, 0, 1, 0, 0, 0, 4, 0, 0), pc: 1'b1, flush: 1'b0};
    tbl[9]  = '{s: mk(8, 0, 0, 1, 8, 0, 0, 0, 0, 0), pc: 1'b1, flush: 1'b0};
    tbl[10] = '{s: mk(5, 0, 0, 0, 5, 1, 1, 0, 0, 1), pc: 1'b0, flush: 1'b0};
    tbl[11] = '{s: mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0), pc: 1'b1, flush: 1'b0};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].s, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_pc", i), 32'(last[3]), 32'(tbl[i].pc));
      check($sformatf("tbl%0d_flush", i), 32'(last[1]), 32'(tbl[i].flush));
      step(clean, "tbl_drain");
      step(clean, "tbl_drain");
    end

    lu = mk(5, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    bl = mk(0, 7, 1, 1, 7, 1, 1, 0, 0, 0);
    ba = mk(3, 0, 0, 1, 3, 1, 0, 0, 0, 0);

    step(lu, "lu_c1");    check("lu_c1_exp", 32'(last), 32'(4'b0010));
    step(clean, "lu_c2"); check("lu_c2_exp", 32'(last), 32'(4'b1100));

    c0 = m_cnt;
    step(bl, "bl_c1");    check("bl_c1_exp", 32'(last), 32'(4'b0010));
    step(bl, "bl_c2");    check("bl_c2_exp", 32'(last), 32'(4'b0011));
    step(clean, "bl_c3"); check("bl_c3_exp", 32'(last), 32'(4'b1100));
    check("bl_model_cnt2", 32'(m_cnt - c0), 32'd2);

    step(ba, "ba_c1");    check("ba_c1_exp", 32'(last), 32'(4'b0010));
    step(clean, "ba_c2"); check("ba_c2_exp", 32'(last), 32'(4'b1100));

    step(bl, "fz_det");   check("fz_det_exp", 32'(last), 32'(4'b0010));
    r = clean; r.frz = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(r, "fz_hold"); check("fz_hold_exp", 32'(last), 32'(4'b0001));
    end
    step(clean, "fz_rel"); check("fz_rel_exp", 32'(last), 32'(4'b0011));
    step(clean, "fz_end"); check("fz_end_exp", 32'(last), 32'(4'b1100));

    step(bl, "rst_det");  check("rst_det_exp", 32'(last), 32'(4'b0010));
    drive(bl);
    rst_n = 1'b0;
    #1;
    last = {bus.pc_write, bus.if_id_write, bus.id_ex_flush, bus.stall_active};
    check("rst_mid_hold", 32'(last), 32'(4'b1100));
`ifdef HAZARD_STATS_EN
    check("rst_mid_count", 32'(bus.stall_count), 32'd0);
`endif
    m_hold = 0;
    m_cnt  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(clean, "rst_after"); check("rst_after_exp", 32'(last), 32'(4'b1100));

    for (int i = 0; i < 600; i++) begin
      r.rs    = 5'($urandom_range(0, 3));
      r.rt    = 5'($urandom_range(0, 3));
      r.uses  = 1'($urandom_range(0, 1));
      r.br    = 1'($urandom_range(0, 1));
      r.rd_ex = 5'($urandom_range(0, 3));
      r.rw_ex = 1'($urandom_range(0, 1));
      r.mr_ex = 1'($urandom_range(0, 1));
      r.rd_m  = 5'($urandom_range(0, 3));
      r.mr_m  = 1'($urandom_range(0, 1));
      r.frz   = ($urandom_range(0, 7) == 0);
      step(r, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Reset-time stimulus: a live load-use hazard that reset must mask.
  function automatic stim_t lu_hazard();
    return mk(5, 0, 0, 0, 5, 1, 1, 0, 0, 0);
  endfunction

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

ID-stage hazard and stall controller: the stall-side counterpart to the ID forwarding logic. It detects the dependencies that forwarding cannot resolve, such as load-use and branch-in-ID operand hazards. It sequences the required 1- or 2-cycle stalls through a registered FSM and drives PC/IF-ID write enables and the ID/EX bubble. It sits between the ID decode logic and the IF/ID, ID/EX pipeline registers.

## Interface
Parameters:
- REG_W, 5, register-index width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rs_id  in  REG_W  rs of instruction in ID
- rt_id  in  REG_W  rt of instruction in ID
- uses_rt_id  in  1  ID instruction reads rt as a source (R-type, branch, store)
- branch_id  in  1  ID instruction is a branch resolved in ID (needs operands in ID)
- rd_ex  in  REG_W  destination register of instruction in EX
- reg_write_ex  in  1  EX instruction writes a register
- mem_read_ex  in  1  EX instruction is a load
- rd_ex_m  in  REG_W  destination register in EX/MEM
- mem_read_m  in  1  EX/MEM instruction is a load
- freeze  in  1  external pipeline freeze (debug/halt)
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register write enable
- id_ex_flush  out  1  insert bubble into ID/EX (zero control bits)
- stall_active  out  1  registered: FSM is in HOLD
- stall_count  out  16  saturating stall-cycle counter (only with HAZARD_STATS_EN)

## Operation
- Match rules: a match requires a non-zero destination equal to rs_id, or equal to rt_id when uses_rt_id=1. Register 0 never matches.
- Required stall count N, evaluated combinationally in IDLE, highest priority first:
  - branch_id and match on rd_ex with mem_read_ex: N=2.
  - branch_id and match on rd_ex with reg_write_ex (not a load): N=1.
  - branch_id and match on rd_ex_m with mem_read_m: N=1.
  - non-branch, match on rd_ex with mem_read_ex (load-use): N=1.
  - Otherwise N=0.
- FSM states:
  - IDLE: no stall in progress.
  - HOLD: stall in progress; owns the 2-bit register rem_cnt.
- IDLE transitions:
  - N=0: outputs pass through (pc_write=1, if_id_write=1, id_ex_flush=0).
  - N>0: stall in the same cycle (pc_write=0, if_id_write=0, id_ex_flush=1).
  - N=2: next state HOLD with rem_cnt=1.
  - N=1: stay in IDLE. The hazard is cleared because a bubble now occupies EX.
- HOLD behaviour:
  - Stall outputs asserted unconditionally. Inputs are not re-evaluated.
  - rem_cnt decrements each cycle. When rem_cnt reaches 1, next state is IDLE.
- On return to IDLE, detection re-evaluates normally. A fresh hazard from new EX/MEM contents starts a new sequence.
- freeze=1, any state:
  - pc_write=0, if_id_write=0, id_ex_flush=0 (hold the pipeline, no bubble).
  - FSM state, rem_cnt and stall_count hold their values.
  - freeze has priority over all stall outputs.
- Reset, asynchronous on rst_n low:
  - state=IDLE, rem_cnt=0, stall_active=0, stall_count=0.
  - While rst_n is low, outputs are forced to pc_write=1, if_id_write=1, id_ex_flush=0.
  - Reset asserted during HOLD aborts the sequence immediately.

## Timing
- Detection to stall outputs: combinational, 0-cycle latency, in IDLE.
- Load-dependent branch: exactly 2 consecutive stall cycles (IDLE detect, then HOLD), then IDLE at cycle 3.
- stall_active is registered: it is high in the cycles the FSM is in HOLD, not in the detect cycle.
- freeze in the middle of HOLD extends the sequence by the frozen cycles. The stall total still equals N unfrozen cycles.
- All state updates occur on the rising edge of clk with freeze=0.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_count increments on every cycle with id_ex_flush=1 and freeze=0.
  - It saturates at 16'hFFFF and is cleared only by reset.
- HAZARD_STATS_EN undefined: the stall_count port and counter logic are absent. All other behaviour is identical.

## Test plan
- Load-use: rd_ex=5, mem_read_ex=1, rs_id=5, branch_id=0 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1, then pass-through; stall_active stays 0.
- Branch after load: branch_id=1, rt_id=7, uses_rt_id=1, rd_ex=7, mem_read_ex=1 -> 2 stall cycles; stall_active=1 in cycle 2 only; stall_count advances by 2.
- Branch after ALU op: branch_id=1, rs_id=3, rd_ex=3, reg_write_ex=1, mem_read_ex=0 -> exactly 1 stall cycle.
- Register zero: rd_ex=0, mem_read_ex=1, rs_id=0 -> no stall; rt_id=9 with uses_rt_id=0 and rd_ex=9 -> no stall.
- Freeze mid-HOLD: assert freeze for 3 cycles during HOLD -> pc_write=0 and id_ex_flush=0 while frozen; 1 remaining stall cycle after release.
- Reset mid-HOLD: drop rst_n during HOLD -> immediately stall_active=0, pc_write=1, id_ex_flush=0, stall_count=0.
